// File: rtl/btn_pkg.sv
//------------------------------------------------------------------------------
// Module   : btn_pkg
// Purpose  : Shared types and constants for the push-button front-end.
//            Holds the debounce FSM state encoding, register offsets,
//            STATUS bit positions and a STATUS word packing helper.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package btn_pkg;

   // Debounce FSM states, shared by both button instances
   typedef enum logic [1:0] {
      ST_UP     = 2'd0,
      ST_CHK_DN = 2'd1,
      ST_DOWN   = 2'd2,
      ST_CHK_UP = 2'd3
   } btn_state_t;

   // Number of board buttons handled by this block
   localparam int BTN_NUM = 2;

   // Word offsets (address bits [3:2]) within the register window
   localparam logic [1:0] BTN_STATUS_OFF = 2'd0;
   localparam logic [1:0] BTN_COUNT_OFF  = 2'd1;

   // STATUS field positions (each field is BTN_NUM bits wide)
   localparam int BTN_LEVEL_LSB = 0;
   localparam int BTN_PRESS_LSB = 8;
   localparam int BTN_LONG_LSB  = 12;

   // Packs the STATUS word; every bit outside the three fields reads 0
   function automatic logic [31:0] btn_status_word(
      input logic [BTN_NUM-1:0] level,
      input logic [BTN_NUM-1:0] press_flags,
      input logic [BTN_NUM-1:0] long_flags
   );
      logic [31:0] w_word;
      w_word = '0;
      w_word[BTN_LEVEL_LSB +: BTN_NUM] = level;
      w_word[BTN_PRESS_LSB +: BTN_NUM] = press_flags;
      w_word[BTN_LONG_LSB  +: BTN_NUM] = long_flags;
      return w_word;
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
//------------------------------------------------------------------------------
// Module   : btn_debounce
// Purpose  : One push-button channel. Inverts the active-low pin, runs it
//            through a 2-flop synchroniser, then a four-state debounce FSM
//            that only accepts a level after DB_COUNT+1 stable cycles.
//            Emits the debounced level and a one-cycle press pulse.
//            Optional feature macro: BTN_LONGPRESS_EN adds a hold timer
//            that pulses o_long_press once per hold after DB_COUNT cycles
//            settled in DOWN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_debounce
   import btn_pkg::*;
#(
   parameter int               CNT_W    = 24,
   parameter logic [CNT_W-1:0] DB_COUNT = 24'hFFFFFF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn_n,
   output logic o_level,
   output logic o_press,
   output logic o_long_press
);

   logic             r_sync1;
   logic             r_sync2;
   btn_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_cnt_done;

   // The entry cycle into a CHK state counts as the first stable cycle, so
   // the decision is taken on the incremented value.
   assign w_cnt_inc  = r_cnt + CNT_W'(1);
   assign w_cnt_done = (w_cnt_inc == DB_COUNT);

   // Two-flop synchroniser on the inverted pin; resets to "released"
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= ~i_btn_n;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce FSM with registered level and single-cycle press pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_UP;
         r_cnt   <= '0;
         o_level <= 1'b0;
         o_press <= 1'b0;
      end else begin
         o_press <= 1'b0;
         case (r_state)
            ST_UP: begin
               if (r_sync2) begin
                  r_state <= ST_CHK_DN;
                  r_cnt   <= '0;
               end
            end
            ST_CHK_DN: begin
               if (!r_sync2) begin
                  r_state <= ST_UP;
                  r_cnt   <= '0;
               end else if (w_cnt_done) begin
                  r_state <= ST_DOWN;
                  r_cnt   <= '0;
                  o_level <= 1'b1;
                  o_press <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ST_DOWN: begin
               if (!r_sync2) begin
                  r_state <= ST_CHK_UP;
                  r_cnt   <= '0;
               end
            end
            ST_CHK_UP: begin
               if (r_sync2) begin
                  r_state <= ST_DOWN;
                  r_cnt   <= '0;
               end else if (w_cnt_done) begin
                  r_state <= ST_UP;
                  r_cnt   <= '0;
                  o_level <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: begin
               r_state <= ST_UP;
               r_cnt   <= '0;
            end
         endcase
      end
   end

`ifdef BTN_LONGPRESS_EN
   logic [CNT_W-1:0] r_hold;
   logic [CNT_W-1:0] w_hold_inc;

   assign w_hold_inc = r_hold + CNT_W'(1);

   // Hold timer: runs while settled in DOWN, saturates at DB_COUNT so the
   // long-press pulse fires only once per hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold       <= '0;
         o_long_press <= 1'b0;
      end else begin
         o_long_press <= 1'b0;
         if (r_state == ST_DOWN) begin
            if (r_hold != DB_COUNT) begin
               r_hold       <= w_hold_inc;
               o_long_press <= (w_hold_inc == DB_COUNT);
            end
         end else begin
            r_hold <= '0;
         end
      end
   end
`else
   assign o_long_press = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/button_input_ctrl.sv
//------------------------------------------------------------------------------
// Module   : button_input_ctrl
// Purpose  : Memory-mapped front-end for the two board push-buttons.
//            Debounces btn1/btn2 and exposes read-only registers:
//              offset 0x0 STATUS : levels, sticky press flags, long flags
//              offset 0x4 COUNT  : 8-bit wrapping press counters
//              offset 0x8/0xC    : read 0
//            Sticky flags clear on a STATUS read; a same-cycle set wins.
//            Optional feature macro: BTN_LONGPRESS_EN (long-press flags in
//            STATUS[13:12]; without it those bits read 0).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_input_ctrl
   import btn_pkg::*;
#(
   parameter int               CNT_W     = 24,
   parameter logic [CNT_W-1:0] DB_COUNT  = 24'hFFFFFF,
   parameter logic [31:0]      BASE_ADDR = 32'h0000_8000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn1,
   input  logic        btn2,
   input  logic        ren,
   input  logic [31:0] address,
   output logic [31:0] data_out,
   output logic [1:0]  btn_level,
   output logic [1:0]  btn_press
);

   // Word index of the base inside a 16-byte window; register selection is
   // relative to it so a base that is only word-aligned still maps offset 0
   // to STATUS.
   localparam logic [1:0] c_base_sel = BASE_ADDR[3:2];

   logic [BTN_NUM-1:0] w_btn_n;
   logic [BTN_NUM-1:0] w_long_press;
   logic [1:0]         w_off;
   logic               w_status_rd;
   logic [31:0]        w_rd_data;
   logic               w_unused_addr;

   logic [BTN_NUM-1:0] r_press_flag;
   logic [BTN_NUM-1:0] r_long_flag;
   logic [7:0]         r_press_cnt [BTN_NUM];

   assign w_btn_n     = {btn2, btn1};
   assign w_off       = address[3:2] - c_base_sel;
   assign w_status_rd = ren && (w_off == BTN_STATUS_OFF);

   // Chip select is decoded by the bus; the remaining address bits are ignored
   assign w_unused_addr = ^{address[31:4], address[1:0]};

   generate
      for (genvar gi = 0; gi < BTN_NUM; gi++) begin : g_btn
         btn_debounce #(
            .CNT_W    (CNT_W),
            .DB_COUNT (DB_COUNT)
         ) u_debounce (
            .clk          (clk),
            .reset        (reset),
            .i_btn_n      (w_btn_n[gi]),
            .o_level      (btn_level[gi]),
            .o_press      (btn_press[gi]),
            .o_long_press (w_long_press[gi])
         );
      end
   endgenerate

   // Sticky flags: cleared by a STATUS read, but a same-cycle set wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_press_flag <= '0;
         r_long_flag  <= '0;
      end else begin
         r_press_flag <= (r_press_flag & ~{BTN_NUM{w_status_rd}}) | btn_press;
         r_long_flag  <= (r_long_flag  & ~{BTN_NUM{w_status_rd}}) | w_long_press;
      end
   end

   // Press counters: free-running 8-bit wrap, never touched by reads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BTN_NUM; i++) begin
            r_press_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < BTN_NUM; i++) begin
            if (btn_press[i]) begin
               r_press_cnt[i] <= r_press_cnt[i] + 8'd1;
            end
         end
      end
   end

   // Read mux; STATUS shows the flags as they stand before this read clears them
   always_comb begin
      w_rd_data = '0;
      case (w_off)
         BTN_STATUS_OFF: w_rd_data = btn_status_word(btn_level, r_press_flag, r_long_flag);
         BTN_COUNT_OFF:  w_rd_data = {16'h0000, r_press_cnt[1], r_press_cnt[0]};
         default:        w_rd_data = '0;
      endcase
   end

   // Registered read data, held between reads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out <= '0;
      end else if (ren) begin
         data_out <= w_rd_data;
      end
   end

endmodule

`default_nettype wire
